// File: rtl/npu_host_loader.sv
// rtl/npu_host_loader.sv - host packet loader feeding the NPU config and input FIFOs
module npu_host_loader #(
    parameter int TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        host_valid,
    input  logic [31:0] host_data,
    output logic        host_ready,
    output logic [25:0] npu_config_data,
    output logic        npu_config_fifo_write_enable,
    input  logic        npu_config_fifo_full,
    output logic [31:0] npu_input_data,
    output logic        npu_input_fifo_write_enable,
    input  logic        npu_input_fifo_full,
    input  logic        err_clear,
    output logic        loader_busy,
    output logic        err_type,
    output logic        err_pad,
    output logic        err_timeout,
    output logic [15:0] pkt_count
);

    // idle counter only needs to reach TIMEOUT-1; the abort fires on the following idle cycle
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   remaining;
    logic [TW-1:0] idle_cnt;
    logic          xfer;

    always_comb begin
        host_ready = 1'b0;
        if (!RST) begin
            case (state)
                IDLE:    host_ready = 1'b1;
                CFG:     host_ready = !npu_config_fifo_full;
                DATA:    host_ready = !npu_input_fifo_full;
                default: host_ready = 1'b0;
            endcase
        end
    end

    assign xfer                         = host_valid && host_ready;
    assign npu_config_fifo_write_enable = xfer && (state == CFG);
    assign npu_input_fifo_write_enable  = xfer && (state == DATA);
    assign npu_config_data              = host_data[25:0];
    assign npu_input_data               = host_data;
    assign loader_busy                  = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            remaining   <= '0;
            idle_cnt    <= '0;
            pkt_count   <= '0;
            err_type    <= 1'b0;
            err_pad     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // clear first so an error event later in this block takes priority
            if (err_clear) begin
                err_type    <= 1'b0;
                err_pad     <= 1'b0;
                err_timeout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (xfer) begin
                        if (host_data[31]) begin
                            err_type <= 1'b1;
                        end else if (host_data[15:0] == 16'd0) begin
                            pkt_count <= pkt_count + 16'd1;
                        end else begin
                            remaining <= host_data[15:0];
                            state     <= host_data[30] ? DATA : CFG;
                        end
                    end
                end
                CFG, DATA: begin
                    if (xfer) begin
                        idle_cnt  <= '0;
                        remaining <= remaining - 16'd1;
                        if ((state == CFG) && (host_data[31:26] != 6'd0)) begin
                            err_pad <= 1'b1;
                        end
                        if (remaining == 16'd1) begin
                            state     <= IDLE;
                            pkt_count <= pkt_count + 16'd1;
                        end
                    end else if (!host_valid) begin
                        if (idle_cnt == TLAST) begin
                            state       <= IDLE;
                            err_timeout <= 1'b1;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_host_loader.sv
// tb/tb_npu_host_loader.sv - randomized self-checking bench for npu_host_loader
`timescale 1ns/1ps
module tb_npu_host_loader;

    localparam int TOUT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        host_valid = 1'b0;
    logic [31:0] host_data = '0;
    logic        host_ready;
    logic [25:0] npu_config_data;
    logic        npu_config_fifo_write_enable;
    logic        npu_config_fifo_full = 1'b0;
    logic [31:0] npu_input_data;
    logic        npu_input_fifo_write_enable;
    logic        npu_input_fifo_full = 1'b0;
    logic        err_clear = 1'b0;
    logic        loader_busy;
    logic        err_type;
    logic        err_pad;
    logic        err_timeout;
    logic [15:0] pkt_count;

    npu_host_loader #(.TIMEOUT(TOUT)) dut (
        .CLK(CLK),
        .RST(RST),
        .host_valid(host_valid),
        .host_data(host_data),
        .host_ready(host_ready),
        .npu_config_data(npu_config_data),
        .npu_config_fifo_write_enable(npu_config_fifo_write_enable),
        .npu_config_fifo_full(npu_config_fifo_full),
        .npu_input_data(npu_input_data),
        .npu_input_fifo_write_enable(npu_input_fifo_write_enable),
        .npu_input_fifo_full(npu_input_fifo_full),
        .err_clear(err_clear),
        .loader_busy(loader_busy),
        .err_type(err_type),
        .err_pad(err_pad),
        .err_timeout(err_timeout),
        .pkt_count(pkt_count)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [31:0] cfgq[$];
    logic [31:0] inq[$];
    logic [15:0] exp_pkt = '0;
    logic        exp_type = 1'b0;
    logic        exp_pad = 1'b0;
    bit          rand_full = 1'b0;
    bit          gaps = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // write scoreboard: every strobe must match the next word the packet stream predicts
    always @(negedge CLK) begin
        if (!RST) begin
            chk("we_exclusive", {31'd0, npu_config_fifo_write_enable & npu_input_fifo_write_enable}, 32'd0);
            if (npu_config_fifo_write_enable) begin
                chk("cfg_write_expected", {31'd0, cfgq.size() != 0}, 32'd1);
                if (cfgq.size() != 0) chk("cfg_data", {6'd0, npu_config_data}, cfgq.pop_front());
            end
            if (npu_input_fifo_write_enable) begin
                chk("in_write_expected", {31'd0, inq.size() != 0}, 32'd1);
                if (inq.size() != 0) chk("in_data", npu_input_data, inq.pop_front());
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        bit hs;
        hs = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) @(posedge CLK);
        #1;
        host_valid = 1'b1;
        host_data  = w;
        for (int i = 0; i < 200; i++) begin
            if (rand_full) begin
                npu_config_fifo_full = ($urandom_range(0, 3) == 0);
                npu_input_fifo_full  = ($urandom_range(0, 3) == 0);
            end
            @(negedge CLK);
            hs = host_ready;
            @(posedge CLK);
            #1;
            if (hs) break;
        end
        chk("send_accepted", {31'd0, hs}, 32'd1);
        host_valid = 1'b0;
        npu_config_fifo_full = 1'b0;
        npu_input_fifo_full  = 1'b0;
    endtask

    // model: a packet is a header plus its payload; writes and flags follow from the packet rules
    task automatic send_packet(input logic [1:0] typ, input logic [15:0] len, input bit pad_ok);
        logic [31:0] w;
        send_word({typ, 14'($urandom), len});
        if (typ[1]) begin
            exp_type = 1'b1;
            return;
        end
        for (int k = 0; k < int'(len); k++) begin
            w = $urandom;
            if (typ == 2'b00) begin
                if (!(pad_ok && $urandom_range(0, 3) == 0)) w[31:26] = 6'd0;
                if (w[31:26] != 6'd0) exp_pad = 1'b1;
                cfgq.push_back({6'd0, w[25:0]});
            end else begin
                inq.push_back(w);
            end
            send_word(w);
        end
        exp_pkt = exp_pkt + 16'd1;
    endtask

    task automatic check_flags(input string tag, input logic t, input logic p, input logic o);
        chk({tag, "_err_type"}, {31'd0, err_type}, {31'd0, t});
        chk({tag, "_err_pad"}, {31'd0, err_pad}, {31'd0, p});
        chk({tag, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, o});
    endtask

    initial begin
        #12;
        chk("rst_ready", {31'd0, host_ready}, 32'd0);
        chk("rst_cfg_we", {31'd0, npu_config_fifo_write_enable}, 32'd0);
        chk("rst_in_we", {31'd0, npu_input_fifo_write_enable}, 32'd0);
        chk("rst_busy", {31'd0, loader_busy}, 32'd0);
        chk("rst_pkt", {16'd0, pkt_count}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("idle_ready", {31'd0, host_ready}, 32'd1);

        // config packet of three words
        send_word(32'h0000_0003);
        chk("cfg_busy", {31'd0, loader_busy}, 32'd1);
        cfgq.push_back(32'h11); send_word(32'h0000_0011);
        cfgq.push_back(32'h22); send_word(32'h0000_0022);
        cfgq.push_back(32'h33); send_word(32'h0000_0033);
        exp_pkt = exp_pkt + 16'd1;
        chk("cfg_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});
        chk("cfg_done_idle", {31'd0, loader_busy}, 32'd0);
        chk("cfg_q_drained", cfgq.size(), 32'd0);

        // backpressure on a two-word data packet
        send_word(32'h4000_0002);
        npu_input_fifo_full = 1'b1;
        host_valid = 1'b1;
        host_data  = 32'hA5A5_0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_ready", {31'd0, host_ready}, 32'd0);
            chk("bp_no_write", {31'd0, npu_input_fifo_write_enable}, 32'd0);
            @(posedge CLK); #1;
        end
        chk("bp_no_timeout", {31'd0, err_timeout}, 32'd0);
        chk("bp_busy", {31'd0, loader_busy}, 32'd1);
        npu_input_fifo_full = 1'b0;
        inq.push_back(32'hA5A5_0001); send_word(32'hA5A5_0001);
        inq.push_back(32'h5A5A_0002); send_word(32'h5A5A_0002);
        exp_pkt = exp_pkt + 16'd1;
        chk("bp_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});
        chk("bp_q_drained", inq.size(), 32'd0);

        // invalid header, then a config word with padding bits set
        send_word(32'hC000_0001);
        chk("inv_busy", {31'd0, loader_busy}, 32'd0);
        check_flags("inv", 1'b1, 1'b0, 1'b0);
        send_word(32'h0000_0001);
        cfgq.push_back(32'h0000_0001); send_word(32'hFC00_0001);
        exp_pkt = exp_pkt + 16'd1;
        check_flags("pad", 1'b1, 1'b1, 1'b0);
        chk("pad_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});
        send_word(32'h4000_0000);
        exp_pkt = exp_pkt + 16'd1;
        chk("zero_len_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});
        err_clear = 1'b1; @(posedge CLK); #1; err_clear = 1'b0;
        check_flags("clr", 1'b0, 1'b0, 1'b0);

        // timeout: host goes quiet after one of three data words
        send_word(32'h4000_0003);
        inq.push_back(32'h0BAD_F00D); send_word(32'h0BAD_F00D);
        repeat (TOUT - 1) @(posedge CLK);
        #1;
        chk("to_still_busy", {31'd0, loader_busy}, 32'd1);
        @(posedge CLK); #1;
        chk("to_busy", {31'd0, loader_busy}, 32'd0);
        chk("to_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});
        check_flags("to", 1'b0, 1'b0, 1'b1);

        // reset in the middle of a data packet
        send_word(32'h4000_0005);
        inq.push_back(32'h1111_1111); send_word(32'h1111_1111);
        host_valid = 1'b1;
        host_data  = 32'h2222_2222;
        #2;
        RST = 1'b1;
        #1;
        chk("mrst_ready", {31'd0, host_ready}, 32'd0);
        chk("mrst_in_we", {31'd0, npu_input_fifo_write_enable}, 32'd0);
        chk("mrst_busy", {31'd0, loader_busy}, 32'd0);
        chk("mrst_pkt", {16'd0, pkt_count}, 32'd0);
        check_flags("mrst", 1'b0, 1'b0, 1'b0);
        host_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_pkt = '0;
        send_word(32'h0000_0001);
        chk("post_rst_hdr_busy", {31'd0, loader_busy}, 32'd1);
        cfgq.push_back(32'h0000_0077); send_word(32'h8000_0077);
        exp_pkt = exp_pkt + 16'd1;
        check_flags("post_rst", 1'b0, 1'b1, 1'b0);
        send_word(32'h8000_0000);
        host_valid = 1'b1;
        host_data  = 32'hC000_0000;
        err_clear  = 1'b1;
        @(posedge CLK); #1;
        host_valid = 1'b0;
        err_clear  = 1'b0;
        check_flags("clr_vs_err", 1'b1, 1'b0, 1'b0);
        chk("post_rst_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});

        // randomized packet stream with backpressure and short host gaps
        err_clear = 1'b1; @(posedge CLK); #1; err_clear = 1'b0;
        exp_type  = 1'b0;
        exp_pad   = 1'b0;
        rand_full = 1'b1;
        gaps      = 1'b1;
        for (int p = 0; p < 40; p++) begin
            logic [1:0] typ;
            typ = 2'($urandom_range(0, 3));
            send_packet(typ, 16'($urandom_range(0, 6)), 1'b1);
        end
        rand_full = 1'b0;
        gaps      = 1'b0;
        @(posedge CLK); #1;
        chk("rnd_pkt", {16'd0, pkt_count}, {16'd0, exp_pkt});
        chk("rnd_busy", {31'd0, loader_busy}, 32'd0);
        check_flags("rnd", exp_type, exp_pad, 1'b0);
        chk("rnd_cfg_q", cfgq.size(), 32'd0);
        chk("rnd_in_q", inq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/npu_host_loader.md
NPU_HOST_LOADER -- requirements
Module: npu_host_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256: idle cycles allowed mid-packet before abort.
REQ-002 SHALL have port CLK, input, 1 bit: global 100 MHz clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port host_valid, input, 1 bit: host word valid.
REQ-005 SHALL have port host_data, input, 32 bits: host word, either a header or a payload word.
REQ-006 SHALL have port host_ready, output, 1 bit: loader accepts the word this cycle.
REQ-007 SHALL have port npu_config_data, output, 26 bits: word to the NPU config FIFO.
REQ-008 SHALL have port npu_config_fifo_write_enable, output, 1 bit: config FIFO write strobe.
REQ-009 SHALL have port npu_config_fifo_full, input, 1 bit: config FIFO full.
REQ-010 SHALL have port npu_input_data, output, 32 bits: word to the NPU input FIFO.
REQ-011 SHALL have port npu_input_fifo_write_enable, output, 1 bit: input FIFO write strobe.
REQ-012 SHALL have port npu_input_fifo_full, input, 1 bit: input FIFO full.
REQ-013 SHALL have port err_clear, input, 1 bit: clears all sticky error flags.
REQ-014 SHALL have port loader_busy, output, 1 bit: high while mid-packet.
REQ-015 SHALL have port err_type, output, 1 bit: sticky flag for an invalid header type.
REQ-016 SHALL have port err_pad, output, 1 bit: sticky flag for a config word with nonzero bits [31:26].
REQ-017 SHALL have port err_timeout, output, 1 bit: sticky flag for a packet aborted by timeout.
REQ-018 SHALL have port pkt_count, output, 16 bits: count of completed packets, wraps at 65535 -> 0.

Function
REQ-019 Transfer: SHALL occur only when host_valid=1 and host_ready=1 in the same cycle.
REQ-020 Header format: [31:30] is type (00 config, 01 data, 1x invalid); [15:0] is payload length N; other bits ignored.
REQ-021 FSM states SHALL be IDLE, CFG, DATA.
REQ-022 IDLE: host_ready=1; a header transfer with type 00 and N>0 -> CFG; type 01 and N>0 -> DATA; remaining counter loaded with N.
REQ-023 IDLE, valid type with N=0: SHALL stay IDLE and increment pkt_count in the next cycle.
REQ-024 IDLE, invalid type: SHALL drop the header, set err_type, and stay IDLE.
REQ-025 CFG: host_ready = !npu_config_fifo_full.
REQ-026 CFG, on transfer: npu_config_fifo_write_enable=1 combinationally in the same cycle; npu_config_data=host_data[25:0]; remaining decrements.
REQ-027 CFG, transfer with host_data[31:26] != 0: word SHALL still be written and err_pad set.
REQ-028 DATA: same as CFG using npu_input_fifo_full, npu_input_fifo_write_enable and npu_input_data=host_data[31:0].
REQ-029 Strobe exclusivity: write enables SHALL never assert outside their own state, and never both in one cycle.
REQ-030 Packet completion: transfer of the last payload word (remaining=1) SHALL return the FSM to IDLE and increment pkt_count; next header accepted the following cycle.
REQ-031 Timeout counter: reset on every transfer and on entry to CFG/DATA; increments in CFG/DATA each cycle with host_valid=0; holds while host_valid=1 but the FIFO is full.
REQ-032 Timeout abort: counter reaching TIMEOUT SHALL return the FSM to IDLE, set err_timeout, and leave pkt_count unchanged.
REQ-033 loader_busy SHALL equal (state != IDLE).
REQ-034 err_clear=1 SHALL clear all sticky flags next edge; an error event in the same cycle wins (its flag is set).
REQ-035 Data outputs SHALL be don't-care when the matching write enable is 0; drive host_data bits regardless.

Reset
REQ-036 RST=1 SHALL asynchronously force state IDLE, counters 0, pkt_count 0, all err flags 0.
REQ-037 While RST=1, host_ready and both write enables SHALL be 0.
REQ-038 RST mid-packet SHALL discard the remaining count; the first word after release is treated as a header.

Verification
REQ-039 Config packet: header 0x0000_0003, then words 0x0000_0011, 0x0000_0022, 0x0000_0033 -> three config writes with those values, pkt_count=1, FSM in IDLE.
REQ-040 Backpressure: DATA packet N=2 with npu_input_fifo_full=1 for 5 cycles -> host_ready=0, no write, no timeout; after full drops, both words written in order.
REQ-041 Errors: header 0xC000_0001 -> err_type=1, no write, next header processed normally; config word 0xFC00_0001 -> written as 0x000_0001, err_pad=1.
REQ-042 Timeout: TIMEOUT=4, DATA packet N=3, host silent after 1 word -> abort after 4 idle cycles, err_timeout=1, pkt_count unchanged, busy=0.
REQ-043 Reset and clear: RST pulse mid-DATA packet -> outputs 0, IDLE; err_clear asserted together with a new invalid header -> err_type remains 1.
